inst_mem_responder: RTL and testbench
=====================================

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 SHALL have parameter p_num_words, default 256, meaning storage depth in 32-bit words (power of 2, >= 2).
REQ-002 SHALL have parameter p_latency, default 2, meaning cycles from request acceptance to earliest response valid (>= 1).
REQ-003 SHALL have parameter p_opaque_bits, default 8, meaning width of the tag echoed from request to response.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_val  input  1  request valid.
REQ-007 SHALL have port req_rdy  output  1  request ready.
REQ-008 SHALL have port req_op  input  1  operation: 0 = read, 1 = write.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_data  input  32  write data.
REQ-011 SHALL have port req_strb  input  4  write byte enables; bit i enables byte i.
REQ-012 SHALL have port req_opaque  input  p_opaque_bits  request tag.
REQ-013 SHALL have port resp_val  output  1  response valid.
REQ-014 SHALL have port resp_rdy  input  1  response ready.
REQ-015 SHALL have port resp_op  output  1  echoed op.
REQ-016 SHALL have port resp_data  output  32  read data; 0 for writes.
REQ-017 SHALL have port resp_opaque  output  p_opaque_bits  echoed tag.
REQ-018 SHALL have port load_en  input  1  backdoor preload strobe.
REQ-019 SHALL have port load_addr  input  32  backdoor byte address.
REQ-020 SHALL have port load_data  input  32  backdoor full-word data.

Function
REQ-021 SHALL accept a request on each cycle where req_val && req_rdy are both 1.
REQ-022 SHALL index storage by req_addr[log2(p_num_words)+1:2]; bits [1:0] and upper bits are ignored (wrap-around).
REQ-023 SHALL apply an accepted write at the acceptance clock edge, updating only strobed bytes.
REQ-024 SHALL capture read data at the acceptance cycle, so reads reflect all writes/loads accepted in earlier cycles and not same-cycle ones.
REQ-025 SHALL return responses strictly in acceptance order, one per accepted request.
REQ-026 SHALL assert resp_val for a request accepted in cycle T no earlier than cycle T+p_latency, and exactly at T+p_latency when all older responses have been consumed.
REQ-027 SHALL hold resp_val and all resp_* fields stable while resp_val && !resp_rdy.
REQ-028 SHALL consume a response on each cycle where resp_val && resp_rdy.
REQ-029 SHALL track outstanding requests (accepted, not yet consumed) with capacity p_latency+2.
REQ-030 SHALL drive req_rdy = 1 iff !rst && !load_en && outstanding < capacity, with a same-cycle response consume NOT freeing a slot (no combinational resp_rdy -> req_rdy path).
REQ-031 SHALL sustain one request and one response per cycle when resp_rdy is held 1.
REQ-032 SHALL write load_data to the indexed word on any cycle with load_en = 1 and rst = 0; loads do not produce responses.
REQ-033 SHALL implement delay as a p_latency-stage valid-tagged shift pipeline feeding an in-order response FIFO; pipeline stages SHALL stall only when the FIFO would overflow, never reordering or dropping entries.

Reset
REQ-034 SHALL, while rst = 1, drive req_rdy = 0 and resp_val = 0.
REQ-035 SHALL, on a reset edge, clear outstanding count, all pipeline valids and FIFO pointers, discarding in-flight requests (mid-operation reset drops them, no response).
REQ-036 SHALL NOT modify storage contents on reset, and SHALL ignore req_val and load_en while rst = 1.
REQ-037 SHALL drive resp_op, resp_data, resp_opaque to 0 whenever resp_val = 0.

Verification
REQ-038 Load word 0x10 = 0xDEADBEEF; read addr 0x40, opaque 5, resp_rdy=1 -> resp_val exactly 2 cycles after acceptance, data 0xDEADBEEF, opaque 5.
REQ-039 Write addr 0x8, data 0xAABBCCDD, strb 0b0101 over preload 0x11223344; then read 0x8 -> data 0x11BB33DD, write response data 0.
REQ-040 resp_rdy=0, req_val=1 continuously -> exactly 4 requests accepted, then req_rdy=0; release resp_rdy -> 4 responses in order, req_rdy returns next cycle.
REQ-041 Back-to-back 8 reads with resp_rdy=1 -> 8 responses on 8 consecutive cycles, opaques in issue order.
REQ-042 Read addr 0x400 with p_num_words=256 -> returns word 0 (wrap); same-cycle load to word 0 not visible to that read.
REQ-043 Assert rst with 3 requests in flight -> resp_val=0 during and after reset, no stale responses, storage preserved for subsequent reads.

Source files
------------

// File: rtl/inst_mem_responder.sv
// Word-addressed instruction/data memory responder: fixed-latency valid-tagged
// delay pipeline feeding an in-order response FIFO, with a backdoor preload port.
module inst_mem_responder #(
  parameter int p_num_words   = 256,
  parameter int p_latency     = 2,
  parameter int p_opaque_bits = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic                     req_op,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_data,
  input  logic [3:0]               req_strb,
  input  logic [p_opaque_bits-1:0] req_opaque,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic                     resp_op,
  output logic [31:0]              resp_data,
  output logic [p_opaque_bits-1:0] resp_opaque,
  input  logic                     load_en,
  input  logic [31:0]              load_addr,
  input  logic [31:0]              load_data
);

  localparam int AW  = $clog2(p_num_words);
  localparam int CAP = p_latency + 2;
  localparam int CW  = $clog2(CAP + 1);
  localparam int FAW = $clog2(CAP);
  localparam int FD  = 1 << FAW;
  localparam int LS  = p_latency - 1;
  localparam logic [CW-1:0]  CAP_C = CW'(CAP);
  localparam logic [FAW:0]   FD_C  = (FAW + 1)'(FD);

  function automatic logic [31:0] merge_strb(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0] mem_q [p_num_words];

  logic [AW-1:0] req_idx;
  logic [AW-1:0] load_idx;
  logic          unused_addr_bits;

  assign req_idx  = req_addr[AW+1:2];
  assign load_idx = load_addr[AW+1:2];
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0],
                              load_addr[31:AW+2], load_addr[1:0]};

  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          consume;

  logic [p_latency-1:0]     stg_vld_q;
  logic [p_latency-1:0]     stg_op_q;
  logic [31:0]              stg_data_q [p_latency];
  logic [p_opaque_bits-1:0] stg_tag_q  [p_latency];

  logic [FD-1:0]            fifo_op_q;
  logic [31:0]              fifo_data_q [FD];
  logic [p_opaque_bits-1:0] fifo_tag_q  [FD];
  logic [FAW-1:0]           wptr_q, rptr_q;
  logic [FAW:0]             fcnt_q, fcnt_d;

  logic fifo_empty, fifo_full;
  logic bypass, pop, push, stall;

  // Outstanding slots are freed only by registered consumes, so req_rdy never
  // depends combinationally on resp_rdy.
  assign req_rdy = !rst && !load_en && (cnt_q < CAP_C);
  assign accept  = req_val && req_rdy;

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == FD_C);

  assign resp_val = !rst && (!fifo_empty || stg_vld_q[LS]);
  assign consume  = resp_val && resp_rdy;
  assign bypass   = consume && fifo_empty;
  assign pop      = consume && !fifo_empty;
  assign stall    = stg_vld_q[LS] && !bypass && fifo_full;
  assign push     = stg_vld_q[LS] && !bypass && !fifo_full;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !consume)      cnt_d = cnt_q + 1'b1;
    else if (!accept && consume) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (!push && pop) fcnt_d = fcnt_q - 1'b1;
  end

  // Storage: loads take priority; an accepted request is never coincident with a load.
  always_ff @(posedge clk) begin
    if (!rst && load_en) begin
      mem_q[load_idx] <= load_data;
    end else if (accept && req_op) begin
      mem_q[req_idx] <= merge_strb(mem_q[req_idx], req_data, req_strb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      stg_vld_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (!stall) begin
        stg_vld_q[0] <= accept;
        for (int i = 1; i < p_latency; i++) stg_vld_q[i] <= stg_vld_q[i-1];
      end
    end
  end

  // Stage 0 captures read data at acceptance, before that edge's own write lands.
  always_ff @(posedge clk) begin
    if (!stall) begin
      stg_op_q[0]   <= req_op;
      stg_data_q[0] <= req_op ? 32'h0 : mem_q[req_idx];
      stg_tag_q[0]  <= req_opaque;
      for (int i = 1; i < p_latency; i++) begin
        stg_op_q[i]   <= stg_op_q[i-1];
        stg_data_q[i] <= stg_data_q[i-1];
        stg_tag_q[i]  <= stg_tag_q[i-1];
      end
    end
  end

  // Last stage -> response FIFO boundary
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op_q[wptr_q]   <= stg_op_q[LS];
      fifo_data_q[wptr_q] <= stg_data_q[LS];
      fifo_tag_q[wptr_q]  <= stg_tag_q[LS];
    end
  end

  // An empty FIFO lets the last stage drive the response directly.
  always_comb begin
    resp_op     = 1'b0;
    resp_data   = '0;
    resp_opaque = '0;
    if (resp_val) begin
      if (fifo_empty) begin
        resp_op     = stg_op_q[LS];
        resp_data   = stg_data_q[LS];
        resp_opaque = stg_tag_q[LS];
      end else begin
        resp_op     = fifo_op_q[rptr_q];
        resp_data   = fifo_data_q[rptr_q];
        resp_opaque = fifo_tag_q[rptr_q];
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: vector table of single transactions
// plus hand-written backpressure, back-to-back, load-visibility and reset sequences.
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic        req_rdy;
  logic        req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_strb;
  logic [7:0]  req_opaque;
  logic        resp_val;
  logic        resp_rdy;
  logic        resp_op;
  logic [31:0] resp_data;
  logic [7:0]  resp_opaque;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int n_vec = 0;
  int n_err = 0;

  inst_mem_responder #(
    .p_num_words  (256),
    .p_latency    (2),
    .p_opaque_bits(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_strb   (req_strb),
    .req_opaque (req_opaque),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_op    (resp_op),
    .resp_data  (resp_data),
    .resp_opaque(resp_opaque),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [7:0]  tag;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    @(posedge clk); #1;
    load_en   = 1'b0;
  endtask

  // Issue one request with resp_rdy=1 and return what the response looked like.
  task automatic do_req(input logic op, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [7:0] t,
                        output logic [31:0] got_d, output logic [7:0] got_t,
                        output logic got_op, output int lat);
    int w;
    int c;
    req_op = op; req_addr = a; req_data = d; req_strb = s; req_opaque = t;
    req_val = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk("req_accept_timeout", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
    c = 0;
    do begin
      c++;
      @(negedge clk);
    end while (!resp_val && c < 20);
    got_d = resp_data; got_t = resp_opaque; got_op = resp_op; lat = c;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gd;
    logic [7:0]  gt;
    logic        gop;
    int          lat;
    int          acc;
    int          n;
    logic [7:0]  tg [16];
    int          cy [16];
    logic [31:0] dt [16];

    vecs[0]  = '{1'b0, 32'h040, 32'h0,        4'b0000, 8'd5,  32'hDEADBEEF};
    vecs[1]  = '{1'b1, 32'h008, 32'hAABBCCDD, 4'b0101, 8'd6,  32'h0};
    vecs[2]  = '{1'b0, 32'h008, 32'h0,        4'b0000, 8'd7,  32'h11BB33DD};
    vecs[3]  = '{1'b0, 32'h400, 32'h0,        4'b0000, 8'd8,  32'hCAFEF00D};
    vecs[4]  = '{1'b0, 32'h3FE, 32'h0,        4'b0000, 8'd9,  32'h0BADF00D};
    vecs[5]  = '{1'b1, 32'h3FC, 32'h12345678, 4'b1111, 8'd10, 32'h0};
    vecs[6]  = '{1'b0, 32'h7FC, 32'h0,        4'b0000, 8'd11, 32'h12345678};
    vecs[7]  = '{1'b1, 32'h040, 32'hFFFFFFFF, 4'b0000, 8'd12, 32'h0};
    vecs[8]  = '{1'b0, 32'h041, 32'h0,        4'b0000, 8'd13, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 32'h040, 32'h77000000, 4'b1000, 8'd14, 32'h0};
    vecs[10] = '{1'b0, 32'h040, 32'h0,        4'b0000, 8'd15, 32'h77ADBEEF};

    rst = 1'b1; req_val = 1'b1; req_op = 1'b0; req_addr = '0; req_data = '0;
    req_strb = '0; req_opaque = '0; resp_rdy = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_opaque", 32'(resp_opaque), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_val = 1'b0;
    @(negedge clk);
    chk("post_rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("idle_resp_val", 32'(resp_val), 32'd0);
    @(posedge clk); #1;

    do_load(32'h040, 32'hDEADBEEF);
    do_load(32'h008, 32'h11223344);
    do_load(32'h000, 32'hCAFEF00D);
    do_load(32'h3FC, 32'h0BADF00D);

    // Table-driven single transactions
    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].tag,
             gd, gt, gop, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
      chk($sformatf("vec%0d_opaque", i), 32'(gt), 32'(vecs[i].tag));
      chk($sformatf("vec%0d_op", i), 32'(gop), 32'(vecs[i].op));
    end

    // Backpressure: capacity of 4 outstanding, stable held response
    resp_rdy = 1'b0;
    req_val = 1'b1; req_op = 1'b0; req_addr = 32'h040; req_opaque = 8'd20;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      logic rdy;
      @(negedge clk);
      rdy = req_rdy;
      if (resp_val) chk("bp_held_opaque", 32'(resp_opaque), 32'd20);
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        req_opaque = req_opaque + 8'd1;
      end
    end
    chk("bp_accepted", 32'(acc), 32'd4);
    @(negedge clk);
    chk("bp_req_rdy_full", 32'(req_rdy), 32'd0);
    @(posedge clk); #1;
    req_val = 1'b0;
    resp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_resp_val", 32'(resp_val), 32'd1);
      chk("bp_resp_opaque", 32'(resp_opaque), 32'(20 + i));
      chk("bp_resp_data", resp_data, 32'h77ADBEEF);
      if (i == 0) chk("bp_req_rdy_same_cycle", 32'(req_rdy), 32'd0);
      if (i == 1) chk("bp_req_rdy_next_cycle", 32'(req_rdy), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_drained", 32'(resp_val), 32'd0);
    @(posedge clk); #1;

    // Back-to-back reads at full throughput
    n = 0;
    for (int k = 0; k < 14; k++) begin
      req_val = (k < 8);
      req_op = 1'b0;
      req_addr = k[0] ? 32'h008 : 32'h040;
      req_opaque = 8'(40 + k);
      @(negedge clk);
      if (k < 8) chk("b2b_req_rdy", 32'(req_rdy), 32'd1);
      if (resp_val && n < 16) begin
        tg[n] = resp_opaque;
        cy[n] = k;
        dt[n] = resp_data;
        n++;
      end
      @(posedge clk); #1;
    end
    req_val = 1'b0;
    chk("b2b_count", 32'(n), 32'd8);
    for (int j = 0; j < 8; j++) begin
      chk("b2b_opaque", 32'(tg[j]), 32'(40 + j));
      chk("b2b_cycle", 32'(cy[j]), 32'(2 + j));
      chk("b2b_data", dt[j], j[0] ? 32'h11BB33DD : 32'h77ADBEEF);
    end

    // Wrapped read captures data before a following load lands
    req_val = 1'b1; req_op = 1'b0; req_addr = 32'h400; req_opaque = 8'd30;
    @(negedge clk);
    chk("wrap_req_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
    load_en = 1'b1; load_addr = 32'h000; load_data = 32'h55555555;
    @(negedge clk);
    chk("load_blocks_req_rdy", 32'(req_rdy), 32'd0);
    @(posedge clk); #1;
    load_en = 1'b0;
    @(negedge clk);
    chk("wrap_resp_val", 32'(resp_val), 32'd1);
    chk("wrap_resp_data", resp_data, 32'hCAFEF00D);
    chk("wrap_resp_opaque", 32'(resp_opaque), 32'd30);
    @(posedge clk); #1;
    do_req(1'b0, 32'h000, 32'h0, 4'b0000, 8'd31, gd, gt, gop, lat);
    chk("load_visible_data", gd, 32'h55555555);

    // Reset with three requests in flight; loads and requests ignored in reset
    resp_rdy = 1'b0;
    req_val = 1'b1; req_op = 1'b0; req_addr = 32'h008;
    for (int k = 0; k < 3; k++) begin
      req_opaque = 8'(60 + k);
      @(posedge clk); #1;
    end
    req_val = 1'b1;
    rst = 1'b1;
    load_en = 1'b1; load_addr = 32'h040; load_data = 32'h0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mid_rst_resp_val", 32'(resp_val), 32'd0);
      chk("mid_rst_req_rdy", 32'(req_rdy), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; load_en = 1'b0; req_val = 1'b0; resp_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(resp_val), 32'd0);
      @(posedge clk); #1;
    end
    do_req(1'b0, 32'h040, 32'h0, 4'b0000, 8'd63, gd, gt, gop, lat);
    chk("rst_preserve_data", gd, 32'h77ADBEEF);
    chk("rst_preserve_opaque", 32'(gt), 32'd63);
    chk("rst_preserve_latency", 32'(lat), 32'd2);
    do_req(1'b0, 32'h008, 32'h0, 4'b0000, 8'd64, gd, gt, gop, lat);
    chk("rst_preserve_data2", gd, 32'h11BB33DD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
